// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: datapath widths, the CDB_PACKET broadcast record
// and a small modulo helper used by the round-robin logic.
package cdb_arbiter_pkg;

   localparam int XLEN        = 32;
   localparam int ROB_TAG_LEN = 5;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [XLEN-1:0]        data;
      logic [XLEN-1:0]        target_pc;
      logic                   mispredict;
   } CDB_PACKET;

   // Adds two indices modulo n; callers keep a < n and b <= n.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Round-robin priority picker: the first set request found scanning upward
// from ptr (wrapping) wins; purely combinational.
module rr_priority_picker
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int FU_IDX_LEN = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0]     req,
   input  logic [FU_IDX_LEN-1:0] ptr,
   output logic [NUM_FU-1:0]     grant,
   output logic [FU_IDX_LEN-1:0] idx,
   output logic                  found
);

   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 0; off < NUM_FU; off++) begin
         cand = wrap_add(int'(ptr), off, NUM_FU);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = FU_IDX_LEN'(cand);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per FU, round-robin grant,
// registered CDB broadcast. Optional per-FU stall counters via CDB_STALL_CNT_EN.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int FU_IDX_LEN = $clog2(NUM_FU)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic [NUM_FU-1:0]                     fu_valid,
   input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_rob_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_data,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_target_pc,
   input  logic [NUM_FU-1:0]                     fu_mispredict,
   output logic [NUM_FU-1:0]                     fu_ready,
   output logic                                  cdb_valid,
   output logic [ROB_TAG_LEN-1:0]                cdb_rob_tag,
   output logic [XLEN-1:0]                       cdb_data,
   output logic [XLEN-1:0]                       cdb_target_pc,
   output logic                                  cdb_mispredict
`ifdef CDB_STALL_CNT_EN
   ,
   output logic [NUM_FU-1:0][15:0]               fu_stall_cnt
`endif
);

   CDB_PACKET [NUM_FU-1:0]  hold_q;
   CDB_PACKET               cdb_q;
   logic [NUM_FU-1:0]       hold_valid;
   logic [NUM_FU-1:0]       grant;
   logic [NUM_FU-1:0]       ready;
   logic [FU_IDX_LEN-1:0]   rr_ptr;
   logic [FU_IDX_LEN-1:0]   win_idx;
   logic                    win_found;

   rr_priority_picker #(
      .NUM_FU     (NUM_FU),
      .FU_IDX_LEN (FU_IDX_LEN)
   ) u_picker (
      .req   (hold_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .found (win_found)
   );

   // A buffer being drained this cycle can take a new result on the same edge.
   always_comb begin
      hold_valid = '0;
      ready      = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         hold_valid[i] = hold_q[i].valid;
         ready[i]      = !flush && (!hold_q[i].valid || grant[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
         cdb_q  <= '0;
         rr_ptr <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_FU; i++) hold_q[i].valid <= 1'b0;
         cdb_q.valid <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && ready[i]) begin
               hold_q[i].valid      <= 1'b1;
               hold_q[i].rob_tag    <= fu_rob_tag[i];
               hold_q[i].data       <= fu_data[i];
               hold_q[i].target_pc  <= fu_target_pc[i];
               hold_q[i].mispredict <= fu_mispredict[i];
            end else if (grant[i]) begin
               hold_q[i].valid <= 1'b0;
            end
         end
         if (win_found) begin
            cdb_q  <= hold_q[win_idx];
            rr_ptr <= FU_IDX_LEN'(wrap_add(int'(win_idx), 1, NUM_FU));
         end else begin
            cdb_q.valid <= 1'b0;
         end
      end
   end

   assign fu_ready       = ready;
   assign cdb_valid      = cdb_q.valid;
   assign cdb_rob_tag    = cdb_q.rob_tag;
   assign cdb_data       = cdb_q.data;
   assign cdb_target_pc  = cdb_q.target_pc;
   assign cdb_mispredict = cdb_q.mispredict;

`ifdef CDB_STALL_CNT_EN
   logic [NUM_FU-1:0][15:0] stall_q;

   // Saturating; deliberately survives flush so stall history is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && !ready[i] && stall_q[i] != 16'hFFFF)
               stall_q[i] <= stall_q[i] + 16'd1;
         end
      end
   end

   assign fu_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences
// for async reset / stall counters, and randomized traffic against a model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic                          clk = 1'b0;
   logic                          reset;
   logic                          flush;
   logic [N-1:0]                  fu_valid;
   logic [N-1:0][ROB_TAG_LEN-1:0] fu_rob_tag;
   logic [N-1:0][XLEN-1:0]        fu_data;
   logic [N-1:0][XLEN-1:0]        fu_target_pc;
   logic [N-1:0]                  fu_mispredict;
   logic [N-1:0]                  fu_ready;
   logic                          cdb_valid;
   logic [ROB_TAG_LEN-1:0]        cdb_rob_tag;
   logic [XLEN-1:0]               cdb_data;
   logic [XLEN-1:0]               cdb_target_pc;
   logic                          cdb_mispredict;
`ifdef CDB_STALL_CNT_EN
   logic [N-1:0][15:0]            fu_stall_cnt;
`endif

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .fu_valid       (fu_valid),
      .fu_rob_tag     (fu_rob_tag),
      .fu_data        (fu_data),
      .fu_target_pc   (fu_target_pc),
      .fu_mispredict  (fu_mispredict),
      .fu_ready       (fu_ready),
      .cdb_valid      (cdb_valid),
      .cdb_rob_tag    (cdb_rob_tag),
      .cdb_data       (cdb_data),
      .cdb_target_pc  (cdb_target_pc),
      .cdb_mispredict (cdb_mispredict)
`ifdef CDB_STALL_CNT_EN
      ,
      .fu_stall_cnt   (fu_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks_total  = 0;
   int checks_passed = 0;

   typedef struct {
      logic [N-1:0]                  valid;
      logic [N-1:0][ROB_TAG_LEN-1:0] tag;
      logic [N-1:0][XLEN-1:0]        data;
      logic [N-1:0][XLEN-1:0]        target;
      logic [N-1:0]                  misp;
      logic                          fl;
      logic [N-1:0]                  exp_ready;
      logic                          exp_valid;
      logic                          chk;
      logic [ROB_TAG_LEN-1:0]        exp_tag;
      logic [XLEN-1:0]               exp_data;
      logic [XLEN-1:0]               exp_target;
      logic                          exp_misp;
   } vec_t;

   vec_t tbl[$];
   vec_t v;

   // Default payload is derived from the tag so expectations stay readable.
   function automatic vec_t mkVec(input logic [N-1:0] valid, input int t3, input int t2,
                                  input int t1, input int t0, input logic fl,
                                  input logic [N-1:0] er, input logic ev,
                                  input logic chk, input int et);
      vec_t r;
      r.valid  = valid;
      r.tag[0] = ROB_TAG_LEN'(t0);
      r.tag[1] = ROB_TAG_LEN'(t1);
      r.tag[2] = ROB_TAG_LEN'(t2);
      r.tag[3] = ROB_TAG_LEN'(t3);
      for (int i = 0; i < N; i++) begin
         r.data[i]   = 32'hC0DE_0000 | 32'(r.tag[i]);
         r.target[i] = 32'h0000_1000 + 32'(r.tag[i]) * 4;
         r.misp[i]   = 1'b0;
      end
      r.fl         = fl;
      r.exp_ready  = er;
      r.exp_valid  = ev;
      r.chk        = chk;
      r.exp_tag    = ROB_TAG_LEN'(et);
      r.exp_data   = 32'hC0DE_0000 | 32'(et);
      r.exp_target = 32'h0000_1000 + 32'(et) * 4;
      r.exp_misp   = 1'b0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic checkCdb(input string name, input CDB_PACKET exp, input bit chk_payload);
      checkOutput({name, " cdb_valid"}, 64'(cdb_valid), 64'(exp.valid));
      if (chk_payload) begin
         checkOutput({name, " cdb_rob_tag"}, 64'(cdb_rob_tag), 64'(exp.rob_tag));
         checkOutput({name, " cdb_data"}, 64'(cdb_data), 64'(exp.data));
         checkOutput({name, " cdb_target_pc"}, 64'(cdb_target_pc), 64'(exp.target_pc));
         checkOutput({name, " cdb_mispredict"}, 64'(cdb_mispredict), 64'(exp.mispredict));
      end
   endtask

   task automatic applyStimulus(input vec_t s);
      fu_valid      = s.valid;
      fu_rob_tag    = s.tag;
      fu_data       = s.data;
      fu_target_pc  = s.target;
      fu_mispredict = s.misp;
      flush         = s.fl;
   endtask

   // Reference model: per-FU slot that is either empty or holds one result,
   // plus the round-robin start position and the last broadcast.
   CDB_PACKET m_hold [N];
   int        m_ptr;
   CDB_PACKET m_cdb;

   function automatic void mReset();
      for (int i = 0; i < N; i++) m_hold[i] = '0;
      m_ptr = 0;
      m_cdb = '0;
   endfunction

   function automatic int mWinner();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (m_hold[j].valid) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] mReady();
      logic [N-1:0] r;
      int w;
      w = mWinner();
      for (int i = 0; i < N; i++) r[i] = !flush && (!m_hold[i].valid || w == i);
      return r;
   endfunction

   // Called just after a posedge, while the inputs sampled at that edge are still driven.
   function automatic void mEdge();
      logic [N-1:0] rdy;
      int w;
      rdy = mReady();
      w   = mWinner();
      if (flush) begin
         for (int i = 0; i < N; i++) m_hold[i].valid = 1'b0;
         m_cdb.valid = 1'b0;
         m_ptr       = 0;
         return;
      end
      if (w >= 0) begin
         m_cdb             = m_hold[w];
         m_ptr             = (w + 1) % N;
         m_hold[w].valid   = 1'b0;
      end else begin
         m_cdb.valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (fu_valid[i] && rdy[i]) begin
            m_hold[i].valid      = 1'b1;
            m_hold[i].rob_tag    = fu_rob_tag[i];
            m_hold[i].data       = fu_data[i];
            m_hold[i].target_pc  = fu_target_pc[i];
            m_hold[i].mispredict = fu_mispredict[i];
         end
      end
   endfunction

   logic [N-1:0] exp_rdy;
   logic [N-1:0] hold_pres;
   CDB_PACKET    exp_pkt;

   initial begin
      reset = 1'b1; flush = 1'b0; fu_valid = '0; fu_rob_tag = '0;
      fu_data = '0; fu_target_pc = '0; fu_mispredict = '0;

      // valid     t3 t2 t1 t0 fl ready   ev chk tag
      v = mkVec(4'b0100, 0, 5, 0, 0, 0, 4'b1111, 0, 0, 0); v.data[2] = 32'hDEAD_BEEF; tbl.push_back(v);
      v = mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1, 5); v.exp_data = 32'hDEAD_BEEF; tbl.push_back(v);
      v = mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 1, 5); v.exp_data = 32'hDEAD_BEEF; tbl.push_back(v);
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mkVec(4'b1111, 4, 3, 2, 1, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1, 1, 1));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b0011, 1, 1, 2));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b0111, 1, 1, 3));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1, 4));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0001, 0, 0, 0, 10, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0001, 0, 0, 0, 11, 0, 4'b1111, 1, 1, 10));
      tbl.push_back(mkVec(4'b0001, 0, 0, 0, 12, 0, 4'b1111, 1, 1, 11));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1, 12));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0011, 0, 0, 21, 20, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0011, 0, 0, 23, 22, 0, 4'b1110, 1, 1, 21));
      tbl.push_back(mkVec(4'b0011, 0, 0, 24, 22, 0, 4'b1101, 1, 1, 20));
      tbl.push_back(mkVec(4'b0011, 0, 0, 24, 25, 0, 4'b1110, 1, 1, 23));
      tbl.push_back(mkVec(4'b0001, 0, 0, 0, 25, 0, 4'b1101, 1, 1, 22));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1110, 1, 1, 24));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1, 25));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
      v = mkVec(4'b1000, 7, 0, 0, 0, 0, 4'b1111, 0, 0, 0);
      v.target[3] = 32'h0000_0400; v.misp[3] = 1'b1; tbl.push_back(v);
      v = mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1, 7);
      v.exp_target = 32'h0000_0400; v.exp_misp = 1'b1; tbl.push_back(v);
      tbl.push_back(mkVec(4'b0111, 0, 15, 14, 13, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b1111, 19, 18, 17, 16, 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
      tbl.push_back(mkVec(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0));

      #12;
      checkCdb("in reset", '0, 1'b1);
      checkOutput("in reset fu_ready", 64'(fu_ready), 64'hF);
      @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < tbl.size(); r++) begin
         applyStimulus(tbl[r]);
         #1;
         checkOutput($sformatf("vec%0d fu_ready", r), 64'(fu_ready), 64'(tbl[r].exp_ready));
         @(posedge clk);
         #1;
         exp_pkt.valid      = tbl[r].exp_valid;
         exp_pkt.rob_tag    = tbl[r].exp_tag;
         exp_pkt.data       = tbl[r].exp_data;
         exp_pkt.target_pc  = tbl[r].exp_target;
         exp_pkt.mispredict = tbl[r].exp_misp;
         checkCdb($sformatf("vec%0d", r), exp_pkt, tbl[r].chk);
         @(negedge clk);
      end

      // Async reset in the middle of a cycle with a result still pending.
      flush = 1'b0; fu_valid = 4'b0011;
      fu_rob_tag[0] = 5'd8; fu_rob_tag[1] = 5'd9;
      fu_data[0] = 32'h1111_2222; fu_target_pc[0] = 32'h3333_4444; fu_mispredict[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      fu_valid = '0;
      @(posedge clk); #1;
      checkOutput("pre-reset cdb_valid", 64'(cdb_valid), 64'h1);
      checkOutput("pre-reset cdb_rob_tag", 64'(cdb_rob_tag), 64'd8);
      #1 reset = 1'b1;
      #1;
      checkCdb("async reset", '0, 1'b1);
      checkOutput("async reset fu_ready", 64'(fu_ready), 64'hF);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("post-reset drop cdb_valid", 64'(cdb_valid), 64'h0);
      @(negedge clk);

`ifdef CDB_STALL_CNT_EN
      // Flush holds fu_ready low, so FU0 is blocked on each of these edges.
      flush = 1'b1; fu_valid = 4'b0001;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_cnt[0]", 64'(fu_stall_cnt[0]), 64'd3);
      checkOutput("stall_cnt[1]", 64'(fu_stall_cnt[1]), 64'd0);
      flush = 1'b0; fu_valid = '0;
      reset = 1'b1;
      #1;
      checkOutput("stall_cnt[0] after reset", 64'(fu_stall_cnt[0]), 64'd0);
      reset = 1'b0;
      @(negedge clk);
`endif

      reset = 1'b1; flush = 1'b0; fu_valid = '0;
      #1 reset = 1'b0;
      mReset();
      hold_pres = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!hold_pres[i]) begin
               fu_valid[i]      = ($urandom_range(0, 9) < 6);
               fu_rob_tag[i]    = ROB_TAG_LEN'($urandom_range(0, 31));
               fu_data[i]       = $urandom();
               fu_target_pc[i]  = $urandom();
               fu_mispredict[i] = 1'($urandom_range(0, 1));
            end
         end
         flush = ($urandom_range(0, 15) == 0);
         #1;
         exp_rdy = mReady();
         checkOutput($sformatf("rand%0d fu_ready", c), 64'(fu_ready), 64'(exp_rdy));
         hold_pres = fu_valid & ~exp_rdy;
         @(posedge clk);
         mEdge();
         #1;
         checkCdb($sformatf("rand%0d", c), m_cdb, 1'b1);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
